// File: rtl/training_controller.sv
// Run controller between a sample source and a streaming network: issues samples
// with an in-flight limit, queues teacher labels in training runs, forwards results in inference.
module training_controller #(
  parameter int unsigned NI    = 8,
  parameter int unsigned NO    = 5,
  parameter int unsigned WF    = 4,
  parameter int unsigned WO    = 7,
  parameter int unsigned NS    = 16,
  parameter int unsigned NE    = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iStart,
  input  logic                      iTrain,
  output logic                      oMode,
  output logic                      oBusy,
  output logic                      oDone,
  output logic [$clog2(NE+1)-1:0]   oEpoch,
  input  logic                      iValid_AS_Sample,
  output logic                      oReady_AS_Sample,
  input  logic [NI*WF-1:0]          iData_AS_Sample,
  input  logic [NO*WO-1:0]          iData_AS_Label,
  output logic                      oValid_BM_Input,
  input  logic                      iReady_BM_Input,
  output logic [NI*WF-1:0]          oData_BM_Input,
  output logic                      oValid_BM_Teacher,
  input  logic                      iReady_BM_Teacher,
  output logic [NO*WO-1:0]          oData_BM_Teacher,
  input  logic                      iValid_AM_Output,
  output logic                      oReady_AM_Output,
  input  logic [NO*WO-1:0]          iData_AM_Output,
  output logic                      oValid_BM_Result,
  input  logic                      iReady_BM_Result,
  output logic [NO*WO-1:0]          oData_BM_Result
);

  localparam int unsigned OW = NO * WO;
  localparam int unsigned EW = $clog2(NE + 1);
  localparam int unsigned CW = $clog2(NS + 1);
  localparam int unsigned FW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [EW-1:0]   epoch_q, epoch_d;
  logic [CW-1:0]   issued_q, issued_d;
  logic [CW-1:0]   returned_q, returned_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   mem_q [DEPTH];

  logic [CW-1:0]   inflight;
  logic            fifo_full;
  logic            issue_en;
  logic            sample_hs;
  logic            push;
  logic            pop;
  logic            out_hs;

  assign inflight  = issued_q - returned_q;
  assign fifo_full = (fcnt_q == FW'(DEPTH));
  assign issue_en  = !iRST && (state_q == S_ISSUE) && (32'(issued_q) < NS)
                     && (32'(inflight) < DEPTH) && (!mode_q || !fifo_full);

  assign oValid_BM_Input  = iValid_AS_Sample & issue_en;
  assign oReady_AS_Sample = iReady_BM_Input & issue_en;
  assign oData_BM_Input   = iData_AS_Sample;

  assign sample_hs = iValid_AS_Sample & iReady_BM_Input & issue_en;
  assign push      = sample_hs & mode_q;

  assign oValid_BM_Teacher = (fcnt_q != '0);
  assign oData_BM_Teacher  = mem_q[rd_ptr_q];
  assign pop               = oValid_BM_Teacher & iReady_BM_Teacher;

  // Training discards network outputs; inference forwards them untouched.
  assign oReady_AM_Output = mode_q | iReady_BM_Result;
  assign oValid_BM_Result = !iRST && !mode_q && iValid_AM_Output;
  assign oData_BM_Result  = iData_AM_Output;
  assign out_hs           = iValid_AM_Output & oReady_AM_Output;

  assign oMode  = mode_q;
  assign oBusy  = busy_q;
  assign oDone  = done_q;
  assign oEpoch = epoch_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    epoch_d    = epoch_q;
    done_d     = 1'b0;
    issued_d   = issued_q + CW'(sample_hs);
    returned_d = (out_hs && (returned_q != issued_q)) ? returned_q + CW'(1) : returned_q;
    fcnt_d     = fcnt_q + FW'(push) - FW'(pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          mode_d     = iTrain;
          epoch_d    = '0;
          issued_d   = '0;
          returned_d = '0;
          fcnt_d     = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issued_q == CW'(NS)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((returned_q == CW'(NS)) && (fcnt_q == '0)) begin
          if (mode_q) begin
            epoch_d = epoch_q + EW'(1);
            if ((32'(epoch_q) + 32'd1) < NE) begin
              issued_d   = '0;
              returned_d = '0;
              state_d    = S_ISSUE;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      epoch_q    <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      fcnt_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      epoch_q    <= epoch_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      fcnt_q     <= fcnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Label storage needs no reset; validity is tracked by fcnt_q.
  always_ff @(posedge iCLK) begin
    if (push) mem_q[wr_ptr_q] <= iData_AS_Label;
  end

endmodule

// File: tb/tb_training_controller.sv
// Directed bench for training_controller: table of idle-path vectors plus
// scripted inference, in-flight, backpressure, training, busy and reset sequences.
module tb_training_controller;

  localparam int unsigned NI = 8, NO = 5, WF = 4, WO = 7, NS = 4, NE = 2, DEPTH = 2;
  localparam int unsigned IW = NI * WF;
  localparam int unsigned OW = NO * WO;
  localparam int unsigned EW = $clog2(NE + 1);
  localparam logic [OW-1:0] NET_KEY = OW'(64'h5_5555_5555);

  logic clk, iRST, iStart, iTrain;
  logic oMode, oBusy, oDone;
  logic [EW-1:0] oEpoch;
  logic iValid_AS_Sample, oReady_AS_Sample;
  logic [IW-1:0] iData_AS_Sample;
  logic [OW-1:0] iData_AS_Label;
  logic oValid_BM_Input, iReady_BM_Input;
  logic [IW-1:0] oData_BM_Input;
  logic oValid_BM_Teacher, iReady_BM_Teacher;
  logic [OW-1:0] oData_BM_Teacher;
  logic iValid_AM_Output, oReady_AM_Output;
  logic [OW-1:0] iData_AM_Output;
  logic oValid_BM_Result, iReady_BM_Result;
  logic [OW-1:0] oData_BM_Result;

  training_controller #(.NI(NI), .NO(NO), .WF(WF), .WO(WO), .NS(NS), .NE(NE), .DEPTH(DEPTH)) dut (
    .iCLK(clk), .iRST(iRST), .iStart(iStart), .iTrain(iTrain),
    .oMode(oMode), .oBusy(oBusy), .oDone(oDone), .oEpoch(oEpoch),
    .iValid_AS_Sample(iValid_AS_Sample), .oReady_AS_Sample(oReady_AS_Sample),
    .iData_AS_Sample(iData_AS_Sample), .iData_AS_Label(iData_AS_Label),
    .oValid_BM_Input(oValid_BM_Input), .iReady_BM_Input(iReady_BM_Input), .oData_BM_Input(oData_BM_Input),
    .oValid_BM_Teacher(oValid_BM_Teacher), .iReady_BM_Teacher(iReady_BM_Teacher),
    .oData_BM_Teacher(oData_BM_Teacher),
    .iValid_AM_Output(iValid_AM_Output), .oReady_AM_Output(oReady_AM_Output), .iData_AM_Output(iData_AM_Output),
    .oValid_BM_Result(oValid_BM_Result), .iReady_BM_Result(iReady_BM_Result), .oData_BM_Result(oData_BM_Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] sample_of(input int i);
    return IW'(i * 32'h0101_0101 + 32'h10);
  endfunction
  function automatic logic [OW-1:0] label_of(input int i);
    return OW'(i * 291 + 7);
  endfunction
  function automatic logic [OW-1:0] net_f(input logic [IW-1:0] x);
    return OW'(x) ^ NET_KEY;
  endfunction

  // Stimulus controls owned by the main sequence.
  bit src_en = 1'b0, net_en = 1'b0, force_am = 1'b0, teach_block = 1'b0;
  logic [OW-1:0] force_data = '0;

  // Observations owned by the monitor.
  int cyc = 0, in_hs = 0, done_cnt = 0, am_low = 0, hold_viol = 0, tdly = 0, src_idx = 0, last_ep = 0;
  bit prev_pend = 1'b0;
  logic [OW-1:0] res_got[$], teach_got[$], net_data[$];
  int net_due[$], ep_hist[$];

  always @(posedge clk) begin
    if (iRST) begin
      in_hs = 0; done_cnt = 0; am_low = 0; hold_viol = 0; tdly = 0; src_idx = 0; last_ep = 0;
      prev_pend = 1'b0;
      res_got.delete(); teach_got.delete(); net_data.delete(); net_due.delete(); ep_hist.delete();
    end else begin
      if (oValid_BM_Input && iReady_BM_Input) begin
        in_hs++; src_idx++;
        net_data.push_back(net_f(oData_BM_Input));
        net_due.push_back(cyc + 3);
      end
      if (iValid_AM_Output && oReady_AM_Output && !force_am && net_data.size() > 0) begin
        void'(net_data.pop_front()); void'(net_due.pop_front());
      end
      if (oValid_BM_Result && iReady_BM_Result) res_got.push_back(oData_BM_Result);
      if (oValid_BM_Teacher && iReady_BM_Teacher) begin
        teach_got.push_back(oData_BM_Teacher); tdly = 0;
      end else if (oValid_BM_Teacher) tdly++;
      if (oDone) done_cnt++;
      if (oMode && oBusy && !oReady_AM_Output) am_low++;
      if (prev_pend && !oValid_BM_Result) hold_viol++;
      prev_pend = oValid_BM_Result && !iReady_BM_Result;
      if (int'(oEpoch) != last_ep) begin last_ep = int'(oEpoch); ep_hist.push_back(last_ep); end
    end
    cyc++;
  end

  // Source, network and teacher-sink models.
  always @(negedge clk) begin
    iValid_AS_Sample = src_en;
    iData_AS_Sample  = sample_of(src_idx);
    iData_AS_Label   = label_of(src_idx);
    iValid_AM_Output = force_am || (net_en && net_data.size() > 0 && net_due[0] <= cyc);
    iData_AM_Output  = (!force_am && net_data.size() > 0) ? net_data[0] : force_data;
    iReady_BM_Teacher = !teach_block && (tdly >= 5);
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); iRST = 1'b1;
    @(negedge clk); @(negedge clk); iRST = 1'b0;
  endtask

  task automatic start_run(input logic train);
    @(negedge clk); iStart = 1'b1; iTrain = train;
    @(negedge clk); iStart = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk); #1; n++;
      if (oDone) seen = 1'b1;
    end
    check({name, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic check_results(input string name, input int n);
    check({name, "_res_count"}, 64'(res_got.size()), 64'(n));
    for (int i = 0; i < n && i < res_got.size(); i++)
      check($sformatf("%s_res%0d", name, i), 64'(res_got[i]), 64'(net_f(sample_of(i))));
  endtask

  typedef struct {
    logic sv, ir, av, rr;
    logic [OW-1:0] d;
    logic e_rv, e_ar, chk_d;
  } vec_t;
  vec_t tbl[7];

  task automatic apply_vec(input int i);
    src_en = tbl[i].sv; iReady_BM_Input = tbl[i].ir; force_am = tbl[i].av;
    force_data = tbl[i].d; iReady_BM_Result = tbl[i].rr;
    @(negedge clk); #1;
    check($sformatf("tbl%0d_s_ready", i), 64'(oReady_AS_Sample), 64'd0);
    check($sformatf("tbl%0d_in_valid", i), 64'(oValid_BM_Input), 64'd0);
    check($sformatf("tbl%0d_in_data", i), 64'(oData_BM_Input), 64'(sample_of(src_idx)));
    check($sformatf("tbl%0d_res_valid", i), 64'(oValid_BM_Result), 64'(tbl[i].e_rv));
    check($sformatf("tbl%0d_am_ready", i), 64'(oReady_AM_Output), 64'(tbl[i].e_ar));
    if (tbl[i].chk_d) check($sformatf("tbl%0d_res_data", i), 64'(oData_BM_Result), 64'(tbl[i].d));
  endtask

  task automatic restore_ctrl();
    src_en = 1'b1; iReady_BM_Input = 1'b1; force_am = 1'b0; iReady_BM_Result = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0;
    int base_cyc, bp_cyc, n;
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, OW'(64'h1_2345_6789), 1'b1, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, OW'(64'h2_0F0F_0F0F), 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, OW'(64'h7_FFFF_FFFF), 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, OW'(64'h0_0000_0001), 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, OW'(64'h3_AAAA_AAAA), 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, OW'(64'h4_5555_0000), 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, OW'(64'h1_0000_FFFF), 1'b0, 1'b1, 1'b0};

    iRST = 1'b1; iStart = 1'b0; iTrain = 1'b0;
    iReady_BM_Input = 1'b1; iReady_BM_Result = 1'b1;
    src_en = 1'b1; force_am = 1'b1; force_data = OW'(64'h1);

    // Reset state with live upstream/network valids.
    @(negedge clk); #1;
    check("rst_mode", 64'(oMode), 64'd0);
    check("rst_busy", 64'(oBusy), 64'd0);
    check("rst_done", 64'(oDone), 64'd0);
    check("rst_epoch", 64'(oEpoch), 64'd0);
    check("rst_teach_valid", 64'(oValid_BM_Teacher), 64'd0);
    check("rst_in_valid", 64'(oValid_BM_Input), 64'd0);
    check("rst_s_ready", 64'(oReady_AS_Sample), 64'd0);
    check("rst_res_valid", 64'(oValid_BM_Result), 64'd0);
    @(negedge clk); iRST = 1'b0;

    for (int i = 0; i < 4; i++) apply_vec(i);
    restore_ctrl();

    // Inference run with 3-cycle network latency.
    net_en = 1'b1;
    do_reset();
    t0 = $time;
    start_run(1'b0);
    wait_done("inf", 200);
    base_cyc = int'(($time - t0) / 10);
    check("inf_mode", 64'(oMode), 64'd0);
    check("inf_epoch", 64'(oEpoch), 64'd0);
    @(negedge clk); #1;
    check("inf_busy_after", 64'(oBusy), 64'd0);
    check("inf_done_once", 64'(done_cnt), 64'd1);
    check("inf_in_hs", 64'(in_hs), 64'd4);
    check_results("inf", 4);

    // iStart with iTrain toggled while busy.
    do_reset();
    start_run(1'b0);
    @(negedge clk); iStart = 1'b1; iTrain = 1'b1;
    @(negedge clk); iTrain = 1'b0;
    @(negedge clk); iStart = 1'b0; #1;
    check("busy_mode_kept", 64'(oMode), 64'd0);
    wait_done("busy", 200);
    repeat (6) @(negedge clk);
    #1;
    check("busy_idle_after", 64'(oBusy), 64'd0);
    check("busy_single_run", 64'(done_cnt), 64'd1);
    check("busy_mode_final", 64'(oMode), 64'd0);
    check_results("busy", 4);

    // In-flight limit with network output withheld.
    net_en = 1'b0;
    do_reset();
    start_run(1'b0);
    repeat (10) @(negedge clk);
    #1;
    check("lim_in_hs", 64'(in_hs), 64'd2);
    check("lim_s_ready", 64'(oReady_AS_Sample), 64'd0);
    check("lim_in_valid", 64'(oValid_BM_Input), 64'd0);
    net_en = 1'b1;
    wait_done("lim", 200);
    check("lim_in_hs_total", 64'(in_hs), 64'd4);
    check_results("lim", 4);

    // Result backpressure for 10 cycles.
    do_reset();
    t0 = $time;
    start_run(1'b0);
    n = 0;
    while (!oValid_BM_Result && n < 50) begin @(negedge clk); #1; n++; end
    check("bp_valid_seen", 64'(oValid_BM_Result), 64'd1);
    iReady_BM_Result = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("bp_valid_held", 64'(oValid_BM_Result), 64'd1);
    check("bp_no_early_result", 64'(res_got.size()), 64'd0);
    iReady_BM_Result = 1'b1;
    wait_done("bp", 200);
    bp_cyc = int'(($time - t0) / 10);
    check("bp_delayed", 64'(bp_cyc >= base_cyc + 10), 64'd1);
    check("bp_hold_viol", 64'(hold_viol), 64'd0);
    check_results("bp", 4);

    // Training run with slow teacher sink.
    do_reset();
    start_run(1'b1);
    wait_done("trn", 600);
    check("trn_mode", 64'(oMode), 64'd1);
    check("trn_epoch", 64'(oEpoch), 64'd2);
    @(negedge clk); #1;
    check("trn_busy_after", 64'(oBusy), 64'd0);
    check("trn_done_once", 64'(done_cnt), 64'd1);
    check("trn_in_hs", 64'(in_hs), 64'd8);
    check("trn_am_ready_low", 64'(am_low), 64'd0);
    check("trn_no_results", 64'(res_got.size()), 64'd0);
    check("trn_ep_steps", 64'(ep_hist.size()), 64'd2);
    if (ep_hist.size() == 2) begin
      check("trn_ep_first", 64'(ep_hist[0]), 64'd1);
      check("trn_ep_second", 64'(ep_hist[1]), 64'd2);
    end
    check("trn_teach_count", 64'(teach_got.size()), 64'd8);
    for (int i = 0; i < teach_got.size() && i < 8; i++)
      check($sformatf("trn_teach%0d", i), 64'(teach_got[i]), 64'(label_of(i)));

    // Idle output path while mode holds training.
    for (int i = 4; i < 7; i++) apply_vec(i);
    check("idle_mode_held", 64'(oMode), 64'd1);
    restore_ctrl();

    // Asynchronous reset mid-run with two labels queued.
    teach_block = 1'b1;
    do_reset();
    start_run(1'b1);
    n = 0;
    while (in_hs < 2 && n < 50) begin @(negedge clk); #1; n++; end
    repeat (2) @(negedge clk);
    #1;
    check("mid_pre_busy", 64'(oBusy), 64'd1);
    check("mid_pre_teach_valid", 64'(oValid_BM_Teacher), 64'd1);
    check("mid_pre_in_hs", 64'(in_hs), 64'd2);
    @(negedge clk); #2; iRST = 1'b1; #1;
    check("mid_busy", 64'(oBusy), 64'd0);
    check("mid_mode", 64'(oMode), 64'd0);
    check("mid_done", 64'(oDone), 64'd0);
    check("mid_epoch", 64'(oEpoch), 64'd0);
    check("mid_teach_valid", 64'(oValid_BM_Teacher), 64'd0);
    check("mid_in_valid", 64'(oValid_BM_Input), 64'd0);
    check("mid_s_ready", 64'(oReady_AS_Sample), 64'd0);
    check("mid_res_valid", 64'(oValid_BM_Result), 64'd0);
    @(negedge clk); @(negedge clk); iRST = 1'b0; teach_block = 1'b0;
    start_run(1'b0);
    wait_done("post", 200);
    check("post_mode", 64'(oMode), 64'd0);
    @(negedge clk); #1;
    check("post_teach_valid", 64'(oValid_BM_Teacher), 64'd0);
    check_results("post", 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/training_controller.md
TRAINING_CONTROLLER -- requirements
Module: training_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NI, 8, network input count
- NO, 5, network output count
- WF, 4, input element width
- WO, 7, output/teacher element width (matches network output element width)
- NS, 16, samples per pass
- NE, 4, epochs per training run
- DEPTH, 4, max samples in flight; also teacher FIFO depth
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- iCLK, in, 1, clock
- iRST, in, 1, reset; asynchronous, active-high
- iStart, in, 1, run request
- iTrain, in, 1, run type sampled with iStart; 1 = train, 0 = infer
- oMode, out, 1, network mode; 1 = train
- oBusy, out, 1, run active
- oDone, out, 1, one-cycle run-complete pulse
- oEpoch, out, $clog2(NE+1), completed epochs in current run
- iValid_AS_Sample, in, 1, sample valid
- oReady_AS_Sample, out, 1, sample ready
- iData_AS_Sample, in, NI*WF, sample input vector
- iData_AS_Label, in, NO*WO, sample teacher vector
- oValid_BM_Input / iReady_BM_Input / oData_BM_Input, out/in/out, 1/1/NI*WF, network input stream
- oValid_BM_Teacher / iReady_BM_Teacher / oData_BM_Teacher, out/in/out, 1/1/NO*WO, network teacher stream
- iValid_AM_Output / oReady_AM_Output / iData_AM_Output, in/out/in, 1/1/NO*WO, network output stream
- oValid_BM_Result / iReady_BM_Result / oData_BM_Result, out/in/out, 1/1/NO*WO, inference result stream

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-004 IDLE with iStart=1: latch iTrain into oMode, clear all counters, go to ISSUE. iStart SHALL be ignored in every other state.
REQ-005 oMode SHALL change only on the IDLE->ISSUE transition.
REQ-006 issue_en SHALL be defined as: state==ISSUE, and issued<NS, and (issued-returned)<DEPTH, and (oMode=0 or teacher FIFO not full).
REQ-007 The sample-to-input path SHALL be zero-latency combinational.
- oValid_BM_Input = iValid_AS_Sample & issue_en
- oReady_AS_Sample = iReady_BM_Input & issue_en
- oData_BM_Input = iData_AS_Sample
REQ-008 A sample handshake SHALL increment issued. When oMode=1 it SHALL also push iData_AS_Label into the teacher FIFO in the same cycle.
REQ-009 The teacher FIFO SHALL drive oValid_BM_Teacher = not empty and oData_BM_Teacher = head. A teacher handshake SHALL pop the head. A same-cycle push and pop SHALL leave the count unchanged.
REQ-010 When oMode=1, oReady_AM_Output SHALL be 1 and output data SHALL be discarded; oValid_BM_Result SHALL be 0.
REQ-011 When oMode=0, the output path SHALL be a combinational pass-through.
- oValid_BM_Result = iValid_AM_Output
- oReady_AM_Output = iReady_BM_Result
- oData_BM_Result = iData_AM_Output
REQ-012 Each output handshake SHALL increment returned. A same-cycle issue and return SHALL leave the in-flight count (issued-returned) unchanged.
REQ-013 ISSUE SHALL go to DRAIN in the cycle after issued reaches NS.
REQ-014 DRAIN SHALL wait until returned==NS and the teacher FIFO is empty, then take one of these actions:
- oMode=1: increment oEpoch; if the new oEpoch<NE, clear issued and returned and go to ISSUE; otherwise go to DONE.
- oMode=0: go to DONE.
REQ-015 DONE SHALL assert oDone for exactly one cycle and go to IDLE. oMode SHALL hold its last value in IDLE.
REQ-016 oBusy SHALL be 1 in ISSUE and DRAIN, and 0 in IDLE and DONE.
REQ-017 Counter widths SHALL be $clog2(NS+1) for issued/returned and $clog2(DEPTH+1) for the FIFO count. No counter SHALL wrap.
REQ-018 An output handshake when returned==issued is a protocol error. returned SHALL saturate at issued.

Reset
REQ-019 iRST=1 SHALL take effect asynchronously and set:
- state = IDLE
- oMode, oBusy, oDone, oEpoch = 0
- issued, returned = 0
- teacher FIFO emptied; oValid_BM_Teacher = 0
REQ-020 While iRST=1, oValid_BM_Input, oReady_AS_Sample and oValid_BM_Result SHALL be 0.
REQ-021 Reset mid-run SHALL discard all in-flight state. The network SHALL share iRST so that no stale outputs return.

Verification (NS=4, NE=2, DEPTH=2 unless stated)
REQ-022 Inference run: iStart=1, iTrain=0; samples always valid; network returns each output 3 cycles later -> oMode=0, 4 results in order, oDone pulses once, oEpoch=0, oBusy low the cycle after oDone.
REQ-023 In-flight limit: network output withheld -> exactly 2 input handshakes occur, then oReady_AS_Sample=0 until the first output handshake.
REQ-024 Training run: iTrain=1, teacher ready delayed 5 cycles per item -> 8 input handshakes, 8 teachers emitted in label order, oReady_AM_Output constant 1, oEpoch steps 1 then 2, a single oDone.
REQ-025 Busy behaviour: iStart pulsed while oBusy=1 with iTrain toggled -> oMode unchanged and no extra run.
REQ-026 Reset mid-run: iRST asserted during ISSUE with FIFO count 2 -> all outputs at reset values immediately (no clock edge required), FIFO empty; a following inference run completes normally.
REQ-027 Backpressure: iReady_BM_Result=0 for 10 cycles during inference -> oValid_BM_Result held, no result lost, completion delayed by at least 10 cycles.
